alarm_ring_ctrl: RTL and testbench

//  Sequences the alarm after the hr/min compare stage fires: drives the buzzer pattern,

---
 rtl/alarm_ring_ctrl.sv | 136 +++++++++++++
 tb/tb_alarm_ring_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring sequencer: buzzer pattern, snooze/stop handling,
// ring timeout, snooze limit and compare-stage clear ownership.
module alarm_ring_ctrl #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic       alarm_active,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic       alarm_clear,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer,
  output logic       missed,
  output logic [2:0] snooze_cnt
);

  localparam int MAXT = (SNOOZE_SEC > RING_TIMEOUT_SEC) ?
                        SNOOZE_SEC : RING_TIMEOUT_SEC;
  localparam int TW   = $clog2(MAXT + 1);

  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(RING_TIMEOUT_SEC - 1);
  localparam logic [TW-1:0] T_SNZ  = TW'(SNOOZE_SEC);
  localparam logic [2:0]    C_MAX  = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RING,
    S_SNOOZE,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          beep_q, beep_d;
  logic          missed_q, missed_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      beep_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      beep_q   <= beep_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    beep_d   = beep_q;
    missed_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (alarm_en && alarm_active) begin
          state_d = S_RING;
          timer_d = '0;
          beep_d  = 1'b1;
        end
      end
      S_RING: begin
        if (!alarm_en || btn_stop) begin
          state_d = S_HOLD;
          timer_d = '0;
          cnt_d   = '0;
          beep_d  = 1'b0;
        end else if (tick_1hz && timer_q == T_LAST) begin
          state_d  = S_HOLD;
          timer_d  = '0;
          cnt_d    = '0;
          beep_d   = 1'b0;
          missed_d = 1'b1;
        end else if (btn_snooze && cnt_q < C_MAX) begin
          state_d = S_SNOOZE;
          timer_d = T_SNZ;
          cnt_d   = cnt_q + 3'd1;
        end else if (tick_1hz) begin
          timer_d = timer_q + T_ONE;
          beep_d  = ~beep_q;
        end
      end
      S_SNOOZE: begin
        if (!alarm_en || btn_stop) begin
          state_d = S_HOLD;
          timer_d = '0;
          cnt_d   = '0;
          beep_d  = 1'b0;
        end else if (tick_1hz) begin
          if (timer_q == T_ONE) begin
            state_d = S_RING;
            timer_d = '0;
            beep_d  = 1'b1;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
      end
      S_HOLD: begin
        // timer counts ticks seen; leave on the second one
        if (tick_1hz) begin
          if (timer_q == T_ONE) begin
            state_d = S_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ringing     = (state_q == S_RING);
    snoozing    = (state_q == S_SNOOZE);
    alarm_clear = (state_q != S_IDLE);
    buzzer      = ringing & beep_q;
    missed      = missed_q;
    snooze_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench for alarm_ring_ctrl with short timing
// parameters; expected outputs are queued per driven cycle.
module tb_alarm_ring_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       alarm_en = 1'b1;
  logic       alarm_active = 1'b0;
  logic       btn_snooze = 1'b0;
  logic       btn_stop = 1'b0;
  logic       alarm_clear, ringing, snoozing, buzzer, missed;
  logic [2:0] snooze_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sbq[$];

  alarm_ring_ctrl #(
    .SNOOZE_SEC(3),
    .RING_TIMEOUT_SEC(4),
    .MAX_SNOOZE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_1hz(tick_1hz),
    .alarm_en(alarm_en),
    .alarm_active(alarm_active),
    .btn_snooze(btn_snooze),
    .btn_stop(btn_stop),
    .alarm_clear(alarm_clear),
    .ringing(ringing),
    .snoozing(snoozing),
    .buzzer(buzzer),
    .missed(missed),
    .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  // {ringing, snoozing, buzzer, alarm_clear, missed, snooze_cnt}
  function automatic logic [7:0] o(
    input logic r, input logic s, input logic b,
    input logic c, input logic m, input logic [2:0] n
  );
    return {r, s, b, c, m, n};
  endfunction

  task automatic check(
    input string tag, input logic [7:0] got, input logic [7:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // drive one cycle of inputs, queue the post-edge expectation
  task automatic cyc(
    input string tag,
    input logic r, input logic en, input logic act,
    input logic tk, input logic snz, input logic stp,
    input logic [7:0] exp
  );
    sb_t e;
    rst = r; alarm_en = en; alarm_active = act;
    tick_1hz = tk; btn_snooze = snz; btn_stop = stp;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check(e.tag, {ringing, snoozing, buzzer, alarm_clear,
                  missed, snooze_cnt}, e.exp);
  endtask

  initial begin
    // reset with alarm pending, then first ring
    cyc("rst0", 1, 1, 1, 0, 0, 0, o(0,0,0,0,0,0));
    cyc("rst1", 1, 1, 1, 0, 0, 0, o(0,0,0,0,0,0));
    cyc("ring_entry", 0, 1, 1, 0, 0, 0, o(1,0,1,1,0,0));
    // stop, hold through two ticks, no re-ring
    cyc("stop", 0, 1, 1, 0, 0, 1, o(0,0,0,1,0,0));
    cyc("hold_t1", 0, 1, 1, 1, 0, 0, o(0,0,0,1,0,0));
    cyc("hold_wait", 0, 1, 1, 0, 0, 0, o(0,0,0,1,0,0));
    cyc("hold_t2", 0, 1, 1, 1, 0, 0, o(0,0,0,0,0,0));
    cyc("idle_quiet", 0, 1, 0, 0, 0, 0, o(0,0,0,0,0,0));
    cyc("en_low_idle", 0, 0, 1, 0, 0, 0, o(0,0,0,0,0,0));
    // snooze sequence and limit
    cyc("ring2", 0, 1, 1, 0, 0, 0, o(1,0,1,1,0,0));
    cyc("snz1", 0, 1, 0, 0, 1, 0, o(0,1,0,1,0,1));
    cyc("snz1_t1", 0, 1, 0, 1, 0, 0, o(0,1,0,1,0,1));
    cyc("snz1_gap", 0, 1, 0, 0, 0, 0, o(0,1,0,1,0,1));
    cyc("snz1_t2", 0, 1, 0, 1, 0, 0, o(0,1,0,1,0,1));
    cyc("snz1_t3", 0, 1, 0, 1, 0, 0, o(1,0,1,1,0,1));
    cyc("snz2", 0, 1, 0, 0, 1, 0, o(0,1,0,1,0,2));
    cyc("snz2_t1", 0, 1, 0, 1, 0, 0, o(0,1,0,1,0,2));
    cyc("snz2_t2", 0, 1, 0, 1, 0, 0, o(0,1,0,1,0,2));
    cyc("snz2_t3", 0, 1, 0, 1, 0, 0, o(1,0,1,1,0,2));
    cyc("snz3_ign", 0, 1, 0, 0, 1, 0, o(1,0,1,1,0,2));
    cyc("lim_t1", 0, 1, 0, 1, 0, 0, o(1,0,0,1,0,2));
    cyc("lim_snz_t2", 0, 1, 0, 1, 1, 0, o(1,0,1,1,0,2));
    cyc("lim_stop", 0, 1, 0, 0, 0, 1, o(0,0,0,1,0,0));
    cyc("lim_h1", 0, 1, 0, 1, 0, 0, o(0,0,0,1,0,0));
    cyc("lim_h2", 0, 1, 0, 1, 0, 0, o(0,0,0,0,0,0));
    // timeout after one snooze
    cyc("to_ring", 0, 1, 1, 0, 0, 0, o(1,0,1,1,0,0));
    cyc("to_snz", 0, 1, 0, 0, 1, 0, o(0,1,0,1,0,1));
    cyc("to_s1", 0, 1, 0, 1, 0, 0, o(0,1,0,1,0,1));
    cyc("to_s2", 0, 1, 0, 1, 0, 0, o(0,1,0,1,0,1));
    cyc("to_s3", 0, 1, 0, 1, 0, 0, o(1,0,1,1,0,1));
    cyc("beep_t1", 0, 1, 0, 1, 0, 0, o(1,0,0,1,0,1));
    cyc("beep_t2", 0, 1, 0, 1, 0, 0, o(1,0,1,1,0,1));
    cyc("beep_t3", 0, 1, 0, 1, 0, 0, o(1,0,0,1,0,1));
    cyc("beep_gap", 0, 1, 0, 0, 0, 0, o(1,0,0,1,0,1));
    cyc("timeout", 0, 1, 0, 1, 0, 0, o(0,0,0,1,1,0));
    cyc("missed_end", 0, 1, 0, 0, 0, 0, o(0,0,0,1,0,0));
    cyc("to_h1", 0, 1, 0, 1, 0, 0, o(0,0,0,1,0,0));
    cyc("to_h2", 0, 1, 0, 1, 0, 0, o(0,0,0,0,0,0));
    // stop beats snooze
    cyc("pri_ring", 0, 1, 1, 0, 0, 0, o(1,0,1,1,0,0));
    cyc("stop_snz", 0, 1, 0, 0, 1, 1, o(0,0,0,1,0,0));
    cyc("pri_h1", 0, 1, 0, 1, 0, 0, o(0,0,0,1,0,0));
    cyc("pri_h2", 0, 1, 0, 1, 0, 0, o(0,0,0,0,0,0));
    // timeout beats snooze
    cyc("pri2_ring", 0, 1, 1, 0, 0, 0, o(1,0,1,1,0,0));
    cyc("pri2_t1", 0, 1, 0, 1, 0, 0, o(1,0,0,1,0,0));
    cyc("pri2_t2", 0, 1, 0, 1, 0, 0, o(1,0,1,1,0,0));
    cyc("pri2_t3", 0, 1, 0, 1, 0, 0, o(1,0,0,1,0,0));
    cyc("snz_timeout", 0, 1, 0, 1, 1, 0, o(0,0,0,1,1,0));
    cyc("pri2_gap", 0, 1, 0, 0, 0, 0, o(0,0,0,1,0,0));
    cyc("pri2_h1", 0, 1, 0, 1, 0, 0, o(0,0,0,1,0,0));
    cyc("pri2_h2", 0, 1, 0, 1, 0, 0, o(0,0,0,0,0,0));
    // enable drop in snooze, reset in ring
    cyc("en_ring", 0, 1, 1, 0, 0, 0, o(1,0,1,1,0,0));
    cyc("en_snz", 0, 1, 0, 0, 1, 0, o(0,1,0,1,0,1));
    cyc("en_drop", 0, 0, 0, 0, 0, 0, o(0,0,0,1,0,0));
    cyc("en_h1", 0, 1, 0, 1, 0, 0, o(0,0,0,1,0,0));
    cyc("en_h2", 0, 1, 0, 1, 0, 0, o(0,0,0,0,0,0));
    cyc("rr_ring", 0, 1, 1, 0, 0, 0, o(1,0,1,1,0,0));
    cyc("rr_t1", 0, 1, 1, 1, 0, 0, o(1,0,0,1,0,0));
    cyc("rr_rst", 1, 1, 1, 0, 0, 0, o(0,0,0,0,0,0));
    cyc("rr_idle", 0, 1, 0, 0, 0, 0, o(0,0,0,0,0,0));
    check("sb_empty", 8'(sbq.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
